// File: rtl/uart_pkg.sv
// uart_pkg -- shared transmitter state encoding and baud helper, rev 1.0
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } tx_state_t;

   function automatic int clks_per_bit(input int fclk, input int baud);
      return fclk / baud;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- synchronous FIFO with registered full/empty/level flags, rev 1.0
`default_nettype none

module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic                     empty_next,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level_next;
   logic             push;
   logic             pop;

   // Write acceptance uses the registered full flag only; a same-cycle pop does not free a slot.
   assign push = wr_en && !full;
   assign pop  = rd_en && !empty;

   always_comb begin
      level_next = level;
      if (push && !pop) begin
         level_next = level + (AW+1)'(1);
      end else if (pop && !push) begin
         level_next = level - (AW+1)'(1);
      end
   end

   assign empty_next = (level_next == '0);
   assign rd_data    = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level <= level_next;
         full  <= (level_next == (AW+1)'(DEPTH));
         empty <= empty_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buf.sv
// uart_tx_buf -- FIFO-buffered UART transmitter (start, WIDTH data LSB-first, stop), rev 1.0
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
`default_nettype none

module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int FCLK  = 50000000,
   parameter int BAUD  = 115200,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     wr_en_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     tx_o,
   output logic                     idle_o
);

   localparam int CPB = clks_per_bit(FCLK, BAUD);
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   tx_state_t        state;
   tx_state_t        state_n;
   logic [CW-1:0]    baud_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift;
   logic             bit_end;
   logic             pop;
   logic             tx_n;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_empty;
   logic             fifo_empty_next;
`ifdef UART_TX_PARITY_EN
   logic             parity;
`endif

   uart_tx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_data    (data_i),
      .wr_en      (wr_en_i),
      .rd_en      (pop),
      .rd_data    (fifo_data),
      .full       (full_o),
      .empty      (fifo_empty),
      .empty_next (fifo_empty_next),
      .level      (level_o)
   );

   assign empty_o = fifo_empty;
   assign bit_end = (baud_cnt == CW'(CPB - 1));

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = S_START;
            end
         end
         S_START: begin
            if (bit_end) state_n = S_DATA;
         end
         S_DATA: begin
            if (bit_end && (bit_cnt == BW'(WIDTH - 1))) begin
`ifdef UART_TX_PARITY_EN
               state_n = S_PARITY;
`else
               state_n = S_STOP;
`endif
            end
         end
         S_PARITY: begin
            if (bit_end) state_n = S_STOP;
         end
         S_STOP: begin
            // Back-to-back frames: the next start bit follows the stop bit with no idle cycle.
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_n = S_START;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      tx_n = 1'b1;
      case (state)
         S_START:  tx_n = 1'b0;
         S_DATA:   tx_n = shift[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_n = parity;
`endif
         default:  tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         tx_o     <= 1'b1;
         idle_o   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity   <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         tx_o   <= tx_n;
         idle_o <= (state_n == S_IDLE) && fifo_empty_next;
         if (pop) begin
            shift    <= fifo_data;
            bit_cnt  <= '0;
            baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= ^fifo_data;
`endif
         end else if (state != S_IDLE) begin
            if (bit_end) begin
               baud_cnt <= '0;
               if (state == S_DATA) begin
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + BW'(1);
               end
            end else begin
               baud_cnt <= baud_cnt + CW'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf -- randomized and directed bench for uart_tx_buf against a frame-level model.
`default_nettype none

module tb_uart_tx_buf;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int FCLK  = 1000000;
   localparam int BAUD  = 75000;
   localparam int CPB   = FCLK / BAUD;   // 13 after truncation
`ifdef UART_TX_PARITY_EN
   localparam int FB    = WIDTH + 3;
   localparam string A5_BITS = "01010010101";
   localparam string H07_BITS = "01110000011";
`else
   localparam int FB    = WIDTH + 2;
   localparam string A5_BITS = "0101001011";
   localparam string H07_BITS = "0111000001";
`endif
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] data = '0;
   logic             full;
   logic             empty;
   logic [LW-1:0]    level;
   logic             tx;
   logic             idle;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_buf #(
      .WIDTH (WIDTH),
      .FCLK  (FCLK),
      .BAUD  (BAUD),
      .DEPTH (DEPTH)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .data_i  (data),
      .wr_en_i (wr_en),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level),
      .tx_o    (tx),
      .idle_o  (idle)
   );

   // Model: queue of stored words plus a frame timer over FB*CPB cycles.
   logic [WIDTH-1:0] mq[$];
   bit               m_busy = 1'b0;
   int               m_t = 0;
   logic [FB-1:0]    m_frame = '1;
   logic             m_tx = 1'b1;

   function automatic logic [FB-1:0] build_frame(input logic [WIDTH-1:0] w);
      logic [FB-1:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < WIDTH; i++) f[i+1] = w[i];
`ifdef UART_TX_PARITY_EN
      f[WIDTH+1] = ^w;
`endif
      return f;
   endfunction

   task automatic model_step();
      bit accept;
      bit frame_end;
      if (rst) begin
         mq.delete();
         m_busy = 1'b0;
         m_t    = 0;
         m_tx   = 1'b1;
      end else begin
         m_tx      = m_busy ? m_frame[m_t / CPB] : 1'b1;
         accept    = wr_en && (mq.size() < DEPTH);
         frame_end = m_busy && (m_t == FB*CPB - 1);
         if (m_busy && !frame_end) begin
            m_t++;
         end else if (mq.size() > 0) begin
            m_frame = build_frame(mq.pop_front());
            m_busy  = 1'b1;
            m_t     = 0;
         end else begin
            m_busy = 1'b0;
            m_t    = 0;
         end
         if (accept) mq.push_back(data);
      end
   endtask

   always @(posedge clk or posedge rst) model_step();

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("tx",    int'(tx),    int'(m_tx));
         chk("idle",  int'(idle),  int'(!m_busy && mq.size() == 0));
         chk("full",  int'(full),  int'(mq.size() == DEPTH));
         chk("empty", int'(empty), int'(mq.size() == 0));
         chk("level", int'(level), mq.size());
      end
   end

   logic [WIDTH-1:0] wq[$];

   // Writes every word of wq on consecutive cycles; returns at the negedge after the last write edge.
   task automatic burst_q();
      foreach (wq[i]) begin
         @(negedge clk);
         data  = wq[i];
         wr_en = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int k;
      k = 0;
      while (!idle && k < max_cycles) begin
         @(negedge clk);
         k++;
      end
      chk("wait_idle", int'(idle), 1);
   endtask

   task automatic frame_test(input logic [WIDTH-1:0] w, input string bits, input string name);
      wq = '{w};
      burst_q();
      @(negedge clk);
      chk($sformatf("%s_lat1", name), int'(tx), 1);
      @(negedge clk);
      chk($sformatf("%s_lat2", name), int'(tx), 0);
      repeat (CPB/2) @(negedge clk);
      for (int k = 0; k < FB; k++) begin
         if (k > 0) repeat (CPB) @(negedge clk);
         chk($sformatf("%s_bit%0d", name, k), int'(tx), int'(bits[k] == "1"));
      end
      wait_idle(2*CPB);
   endtask

   initial begin
      int cnt;
      int k;
      int zeros;
      int p;

      repeat (3) @(negedge clk);
      chk("rst_tx",    int'(tx),    1);
      chk("rst_idle",  int'(idle),  1);
      chk("rst_full",  int'(full),  0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_level", int'(level), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      frame_test(8'hA5, A5_BITS, "a5");

      // Three words back to back: idle_o stays low for exactly three frames plus the fill cycle.
      wq = '{8'h11, 8'h22, 8'h33};
      burst_q();
      cnt = 3;
      for (int i = 0; i < 3*FB*CPB + 20; i++) begin
         @(negedge clk);
         if (idle) break;
         cnt++;
      end
      chk("burst3_span", cnt, 3*FB*CPB + 1);

      // Overflow: DEPTH+2 writes from idle, first word popped, last word dropped.
      wq.delete();
      for (int i = 0; i < DEPTH + 2; i++) wq.push_back(WIDTH'(i*7 + 3));
      burst_q();
      chk("ovf_full",  int'(full),  1);
      chk("ovf_level", int'(level), DEPTH);
      wait_idle((DEPTH + 2)*FB*CPB + 20);

      // Write landing on the same edge as the stop-bit pop keeps the level constant.
      wq.delete();
      for (int i = 0; i < DEPTH; i++) wq.push_back(WIDTH'(8'h40 + i));
      burst_q();
      chk("pp_level_before", int'(level), DEPTH - 1);
      k = 0;
      while (!(m_busy && m_t == FB*CPB - 1) && k < 2*FB*CPB) begin
         @(negedge clk);
         k++;
      end
      chk("pp_sync", int'(k < 2*FB*CPB), 1);
      data  = 8'hEE;
      wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      chk("pp_level_after", int'(level), DEPTH - 1);
      wait_idle((DEPTH + 1)*FB*CPB + 20);

      // Reset in the middle of data bit 3 of an all-zero word.
      wq = '{8'h00, 8'h00, 8'h00};
      burst_q();
      k = 0;
      while (!(m_busy && m_t == 4*CPB + CPB/2) && k < 2*FB*CPB) begin
         @(negedge clk);
         k++;
      end
      chk("mr_sync", int'(k < 2*FB*CPB), 1);
      chk("mr_tx_before", int'(tx), 0);
      #2 rst = 1'b1;
      #1;
      chk("mr_tx",    int'(tx),    1);
      chk("mr_empty", int'(empty), 1);
      chk("mr_level", int'(level), 0);
      chk("mr_idle",  int'(idle),  1);
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      zeros = 0;
      for (int i = 0; i < 2*FB*CPB; i++) begin
         @(negedge clk);
         if (!tx) zeros++;
      end
      chk("mr_no_frame", zeros, 0);

      frame_test(8'h07, H07_BITS, "h07");

      // Randomized traffic: sparse writes, then a dense burst phase that hits full.
      for (int i = 0; i < 2400; i++) begin
         p = (i < 1500) ? 3 : 60;
         @(negedge clk);
         wr_en = ($urandom_range(0, 99) < p);
         data  = WIDTH'($urandom);
      end
      @(negedge clk);
      wr_en = 1'b0;
      wait_idle((DEPTH + 2)*FB*CPB + 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
